interval_timer: RTL and testbench

//  Programmable countdown timer serving the traffic-light FSM. Holds three

---
 rtl/interval_timer.sv | 139 +++++++++++++
 tb/tb_interval_timer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/interval_timer.sv
// Programmable seconds countdown for the traffic-light FSM: three interval
// registers, a clk-to-1 Hz prescaler, and a one-cycle expiry pulse.
module interval_timer #(
  parameter int TICK_DIV = 100_000_000,
  parameter int DEF_BASE = 6,
  parameter int DEF_EXT  = 3,
  parameter int DEF_YEL  = 2
) (
  input  logic       clk,
  input  logic       sys_reset,
  input  logic       prg_sync_in,
  input  logic [1:0] time_param_sel,
  input  logic [3:0] time_value,
  input  logic       start_timer,
  input  logic [1:0] interval_address,
  output logic       expired,
  output logic [3:0] sec_remaining,
  output logic       tick_1hz
);

  localparam int             PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PS_ZERO  = PW'(0);
  localparam logic [PW-1:0]  PS_ONE   = PW'(1);
  localparam logic [PW-1:0]  PS_LAST  = PW'(TICK_DIV - 1);
  localparam logic [3:0]     BASE_RST = 4'(DEF_BASE);
  localparam logic [3:0]     EXT_RST  = 4'(DEF_EXT);
  localparam logic [3:0]     YEL_RST  = 4'(DEF_YEL);
  localparam logic [1:0]     SEL_BASE = 2'b00;
  localparam logic [1:0]     SEL_EXT  = 2'b01;
  localparam logic [1:0]     SEL_YEL  = 2'b10;
  localparam logic [1:0]     SEL_NONE = 2'b11;

  function automatic logic [3:0] default_for(input logic [1:0] sel);
    case (sel)
      SEL_BASE: default_for = BASE_RST;
      SEL_EXT:  default_for = EXT_RST;
      SEL_YEL:  default_for = YEL_RST;
      default:  default_for = BASE_RST;
    endcase
  endfunction

  // A zero-second interval is meaningless, so it falls back to the slot default.
  function automatic logic [3:0] legalize(input logic [1:0] sel, input logic [3:0] val);
    if (val == 4'd0) begin
      legalize = default_for(sel);
    end else begin
      legalize = val;
    end
  endfunction

  logic [3:0]    base_r, ext_r, yel_r;
  logic [3:0]    count_r;
  logic [PW-1:0] prescale_r;
  logic          run_r;
  logic          expired_r;
  logic          tick_r;

  logic          wr_en_s;
  logic [3:0]    wr_val_s;
  logic [1:0]    load_addr_s;
  logic [3:0]    slot_val_s;
  logic [3:0]    load_val_s;

  // Decode the programming write and the load value, including same-edge bypass.
  always_comb begin
    wr_en_s     = prg_sync_in && (time_param_sel != SEL_NONE);
    wr_val_s    = legalize(time_param_sel, time_value);
    load_addr_s = (interval_address == SEL_NONE) ? SEL_BASE : interval_address;
    case (load_addr_s)
      SEL_BASE: slot_val_s = base_r;
      SEL_EXT:  slot_val_s = ext_r;
      SEL_YEL:  slot_val_s = yel_r;
      default:  slot_val_s = base_r;
    endcase
    if (wr_en_s && (time_param_sel == load_addr_s)) begin
      load_val_s = wr_val_s;
    end else begin
      load_val_s = slot_val_s;
    end
  end

  // Interval register file written by the programming strobe.
  always_ff @(posedge clk or posedge sys_reset) begin
    if (sys_reset) begin
      base_r <= BASE_RST;
      ext_r  <= EXT_RST;
      yel_r  <= YEL_RST;
    end else if (wr_en_s) begin
      case (time_param_sel)
        SEL_BASE: base_r <= wr_val_s;
        SEL_EXT:  ext_r  <= wr_val_s;
        SEL_YEL:  yel_r  <= wr_val_s;
        default: begin
          base_r <= base_r;
        end
      endcase
    end
  end

  // Countdown: a load always wins over a tick, so a restart on the expiry edge suppresses the pulse.
  always_ff @(posedge clk or posedge sys_reset) begin
    if (sys_reset) begin
      count_r    <= 4'd0;
      prescale_r <= PS_ZERO;
      run_r      <= 1'b0;
      expired_r  <= 1'b0;
      tick_r     <= 1'b0;
    end else begin
      expired_r <= 1'b0;
      tick_r    <= 1'b0;
      if (start_timer) begin
        count_r    <= load_val_s;
        prescale_r <= PS_ZERO;
        run_r      <= 1'b1;
      end else if (run_r) begin
        if (prescale_r == PS_LAST) begin
          prescale_r <= PS_ZERO;
          tick_r     <= 1'b1;
          if (count_r <= 4'd1) begin
            count_r   <= 4'd0;
            run_r     <= 1'b0;
            expired_r <= 1'b1;
          end else begin
            count_r <= count_r - 4'd1;
          end
        end else begin
          prescale_r <= prescale_r + PS_ONE;
        end
      end else begin
        prescale_r <= PS_ZERO;
      end
    end
  end

  assign expired       = expired_r;
  assign tick_1hz      = tick_r;
  assign sec_remaining = count_r;

endmodule

// File: tb/tb_interval_timer.sv
// Bench for interval_timer: scenario tasks against a time-based reference
// model (deadline = load cycle + N*TICK_DIV), plus randomized traffic.
module tb_interval_timer;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       sys_reset;
  logic       prg_sync_in;
  logic [1:0] time_param_sel;
  logic [3:0] time_value;
  logic       start_timer;
  logic [1:0] interval_address;
  logic       expired;
  logic [3:0] sec_remaining;
  logic       tick_1hz;

  interval_timer #(.TICK_DIV(TD), .DEF_BASE(6), .DEF_EXT(3), .DEF_YEL(2)) dut (
    .clk(clk), .sys_reset(sys_reset), .prg_sync_in(prg_sync_in),
    .time_param_sel(time_param_sel), .time_value(time_value),
    .start_timer(start_timer), .interval_address(interval_address),
    .expired(expired), .sec_remaining(sec_remaining), .tick_1hz(tick_1hz)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: interval slots plus the cycle of the last load.
  int defs [3] = '{6, 3, 2};
  int m_regs [3];
  bit m_run;
  int m_n, m_load, cyc;
  int exp_sec;
  bit exp_tick, exp_exp;

  task automatic reset_model();
    for (int i = 0; i < 3; i++) m_regs[i] = defs[i];
    m_run = 0; exp_sec = 0; exp_tick = 0; exp_exp = 0;
  endtask

  task automatic cycle(input bit st, input int addr, input bit prg, input int sel, input int val);
    int e;
    start_timer = st; interval_address = addr[1:0];
    prg_sync_in = prg; time_param_sel = sel[1:0]; time_value = val[3:0];
    @(posedge clk); #1;
    cyc++;
    if (prg && sel != 3) m_regs[sel] = (val == 0) ? defs[sel] : val;
    exp_tick = 0; exp_exp = 0;
    if (st) begin
      m_run = 1; m_n = m_regs[(addr == 3) ? 0 : addr]; m_load = cyc; exp_sec = m_n;
    end else if (m_run) begin
      e = cyc - m_load;
      exp_sec = m_n - e / TD;
      exp_tick = (e % TD == 0);
      if (e == m_n * TD) begin exp_exp = 1; m_run = 0; end
    end else begin
      exp_sec = 0;
    end
    start_timer = 1'b0; prg_sync_in = 1'b0;
  endtask

  task automatic test_reset();
    sys_reset = 1'b1; start_timer = 1'b1; interval_address = 2'b00;
    prg_sync_in = 1'b1; time_param_sel = 2'b00; time_value = 4'd1;
    reset_model();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({expired, tick_1hz, sec_remaining} !== 6'd0) begin
        miscompares++;
        $display("FAIL reset_state: got exp/tick/sec %b/%b/%0d want 0/0/0", expired, tick_1hz, sec_remaining);
      end
    end
    prg_sync_in = 1'b0;
    #2 sys_reset = 1'b0;
  endtask

  task automatic test_base_countdown();
    int ticks = 0, lc, ec = -1;
    cycle(1, 0, 0, 0, 0); lc = cyc;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) cycle(0, 0, 0, 0, 0);
      vectors++;
      if ({expired, tick_1hz, sec_remaining} !== {exp_exp, exp_tick, 4'(exp_sec)}) begin
        miscompares++;
        $display("FAIL base_cd cyc %0d: got %b/%b/%0d want %b/%b/%0d", cyc, expired, tick_1hz, sec_remaining, exp_exp, exp_tick, exp_sec);
      end
      if (tick_1hz === 1'b1) ticks++;
      if (expired === 1'b1) ec = cyc;
    end
    vectors++;
    if (ticks != 6) begin miscompares++; $display("FAIL base_ticks: got %0d want 6", ticks); end
    vectors++;
    if (ec - lc != 24) begin miscompares++; $display("FAIL base_latency: got %0d want 24", ec - lc); end
  endtask

  task automatic test_program();
    int lc, ec;
    int vals [2] = '{9, 0};
    int want [2] = '{36, 12};
    for (int k = 0; k < 2; k++) begin
      ec = -1;
      cycle(0, 0, 1, 1, vals[k]);
      cycle(1, 1, 0, 0, 0); lc = cyc;
      for (int i = 0; i < 40; i++) begin
        if (i > 0) cycle(0, 0, 0, 0, 0);
        vectors++;
        if ({expired, tick_1hz, sec_remaining} !== {exp_exp, exp_tick, 4'(exp_sec)}) begin
          miscompares++;
          $display("FAIL prog cyc %0d: got %b/%b/%0d want %b/%b/%0d", cyc, expired, tick_1hz, sec_remaining, exp_exp, exp_tick, exp_sec);
        end
        if (expired === 1'b1) ec = cyc;
      end
      vectors++;
      if (ec - lc != want[k]) begin miscompares++; $display("FAIL prog_latency: got %0d want %0d", ec - lc, want[k]); end
    end
  endtask

  task automatic test_restart();
    int lc, ec = -1, pulses = 0;
    cycle(1, 2, 0, 0, 0);
    for (int i = 0; i < 34; i++) begin
      if (i == 4) begin cycle(1, 0, 0, 0, 0); lc = cyc; end
      else cycle(0, 0, 0, 0, 0);
      vectors++;
      if ({expired, tick_1hz, sec_remaining} !== {exp_exp, exp_tick, 4'(exp_sec)}) begin
        miscompares++;
        $display("FAIL restart cyc %0d: got %b/%b/%0d want %b/%b/%0d", cyc, expired, tick_1hz, sec_remaining, exp_exp, exp_tick, exp_sec);
      end
      if (expired === 1'b1) begin ec = cyc; pulses++; end
    end
    vectors++;
    if (pulses != 1 || ec - lc != 24) begin
      miscompares++;
      $display("FAIL restart_pulse: got %0d pulses at %0d want 1 at 24", pulses, ec - lc);
    end
  endtask

  task automatic test_expiry_edge();
    int idle_events = 0, edge_exp = 0;
    cycle(1, 2, 0, 0, 0);
    for (int i = 0; i < 135; i++) begin
      if (i == 7) cycle(1, 1, 0, 0, 0);
      else cycle(0, 0, 0, 0, 0);
      vectors++;
      if ({expired, tick_1hz, sec_remaining} !== {exp_exp, exp_tick, 4'(exp_sec)}) begin
        miscompares++;
        $display("FAIL exp_edge cyc %0d: got %b/%b/%0d want %b/%b/%0d", cyc, expired, tick_1hz, sec_remaining, exp_exp, exp_tick, exp_sec);
      end
      if (i == 7 && expired !== 1'b0) edge_exp++;
      if (i >= 30 && (expired === 1'b1 || tick_1hz === 1'b1)) idle_events++;
    end
    vectors++;
    if (edge_exp != 0) begin miscompares++; $display("FAIL expiry_edge_pulse: got %0d want 0", edge_exp); end
    vectors++;
    if (idle_events != 0) begin miscompares++; $display("FAIL idle_quiet: got %0d events want 0", idle_events); end
  endtask

  task automatic test_async_reset();
    cycle(0, 0, 1, 0, 11);
    cycle(0, 0, 1, 1, 12);
    cycle(0, 0, 1, 2, 13);
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 0);
    #3 sys_reset = 1'b1;
    #1;
    vectors++;
    if ({expired, tick_1hz, sec_remaining} !== 6'd0) begin
      miscompares++;
      $display("FAIL async_reset: got %b/%b/%0d want 0/0/0", expired, tick_1hz, sec_remaining);
    end
    @(posedge clk); #1;
    #2 sys_reset = 1'b0;
    reset_model();
    for (int a = 0; a < 3; a++) begin
      cycle(1, a, 0, 0, 0);
      vectors++;
      if (sec_remaining !== 4'(defs[a])) begin
        miscompares++;
        $display("FAIL reset_regs slot %0d: got %0d want %0d", a, sec_remaining, defs[a]);
      end
    end
  endtask

  task automatic test_bypass();
    int lc, ec = -1;
    cycle(1, 2, 1, 2, 5); lc = cyc;
    for (int i = 0; i < 25; i++) begin
      if (i > 0) cycle(0, 0, 0, 0, 0);
      vectors++;
      if ({expired, tick_1hz, sec_remaining} !== {exp_exp, exp_tick, 4'(exp_sec)}) begin
        miscompares++;
        $display("FAIL bypass cyc %0d: got %b/%b/%0d want %b/%b/%0d", cyc, expired, tick_1hz, sec_remaining, exp_exp, exp_tick, exp_sec);
      end
      if (expired === 1'b1) ec = cyc;
    end
    vectors++;
    if (ec - lc != 20) begin miscompares++; $display("FAIL bypass_latency: got %0d want 20", ec - lc); end
    cycle(0, 0, 1, 3, 9);
    for (int a = 0; a < 4; a++) begin
      cycle(1, a, 0, 0, 0);
      vectors++;
      if (sec_remaining !== 4'(exp_sec)) begin
        miscompares++;
        $display("FAIL sel_none_addr slot %0d: got %0d want %0d", a, sec_remaining, exp_sec);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom % 15) == 0, $urandom % 4, ($urandom % 7) == 0, $urandom % 4, $urandom % 16);
      vectors++;
      if ({expired, tick_1hz, sec_remaining} !== {exp_exp, exp_tick, 4'(exp_sec)}) begin
        miscompares++;
        $display("FAIL random cyc %0d: got %b/%b/%0d want %b/%b/%0d", cyc, expired, tick_1hz, sec_remaining, exp_exp, exp_tick, exp_sec);
      end
    end
  endtask

  initial begin
    cyc = 0;
    test_reset();
    test_base_countdown();
    test_program();
    test_restart();
    test_expiry_edge();
    test_async_reset();
    test_bypass();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
